vga_fps_display: RTL



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_fps_display_seg7_mux.sv | 78 +++++++
 rtl/vga_fps_display.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA FPS display.
// Provides the 7-segment code type, the blank code, and the digit decoder.
package vga_pkg;

    typedef logic [7:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } fps_state_e;

    // Common-anode code {dp,g,f,e,d,c,b,a}, active low, dp unlit.
    function automatic seg7_t seg7_decode(input logic [3:0] d);
        seg7_t s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG7_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction step for one BCD nibble.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/vga_fps_display_seg7_mux.sv
// 3-digit common-anode multiplexer with leading-zero blanking.
// Ports: clk_i, rst_ni, bcd_i[11:0], dp_ni (units dp, active low) -> seg_o, dig_o.
module seg7_mux
    import vga_pkg::*;
#(
    parameter int unsigned DIV = 25000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] bcd_i,
    input  logic        dp_ni,
    output logic [7:0]  seg_o,
    output logic [2:0]  dig_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(DIV - 1);

    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    sel_q, sel_d;
    seg7_t         seg_q, seg_d;
    logic [2:0]    dig_q, dig_d;
    seg7_t         dec_u, dec_t, dec_h;
    logic          blank_h, blank_t;

    always_comb begin
        ref_d   = ref_q + 1'b1;
        sel_d   = sel_q;
        dec_u   = seg7_decode(bcd_i[3:0]);
        dec_t   = seg7_decode(bcd_i[7:4]);
        dec_h   = seg7_decode(bcd_i[11:8]);
        blank_h = (bcd_i[11:8] == 4'd0);
        blank_t = blank_h && (bcd_i[7:4] == 4'd0);
        dig_d   = 3'b111;
        seg_d   = SEG7_BLANK;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end
        case (sel_q)
            2'd0: begin
                dig_d = 3'b110;
                // decoder leaves dp high, so AND-ing drops dp_ni in
                seg_d = dec_u & {dp_ni, 7'h7F};
            end
            2'd1: begin
                dig_d = 3'b101;
                seg_d = blank_t ? SEG7_BLANK : dec_t;
            end
            2'd2: begin
                dig_d = 3'b011;
                seg_d = blank_h ? SEG7_BLANK : dec_h;
            end
            default: begin
                dig_d = 3'b111;
                seg_d = SEG7_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ref_q <= '0;
            sel_q <= 2'd0;
            seg_q <= SEG7_BLANK;
            dig_q <= 3'b111;
        end else begin
            ref_q <= ref_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg_o = seg_q;
    assign dig_o = dig_q;

endmodule

// File: rtl/vga_fps_display.sv
// Frames-per-second meter: 1 s gate, BCD conversion, 7-segment output.
// Ports: clk_i, rst_ni, enable_i, eof_i -> fps_o, bcd_o, valid_o, seg_o, dig_o.
// Define VGA_FPS_DP_EN for a units-digit dp heartbeat toggling per window.
module vga_fps_display
    import vga_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 25_000_000,
    parameter int unsigned DIGIT_REFRESH_HZ = 1000,
    parameter int unsigned FPS_MAX          = 999
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        eof_i,
    output logic [9:0]  fps_o,
    output logic [11:0] bcd_o,
    output logic        valid_o,
    output logic [7:0]  seg_o,
    output logic [2:0]  dig_o
);

    localparam int unsigned GW = $clog2(CLK_FREQ_HZ);
    localparam logic [GW-1:0] GATE_LAST = GW'(CLK_FREQ_HZ - 1);
    localparam logic [9:0] FMAX = 10'(FPS_MAX);

    logic [GW-1:0] gate_q, gate_d;
    logic [9:0]    frm_q, frm_d, frm_inc;
    logic [9:0]    fps_q, fps_d;
    logic          start_q;
    logic          win_end;

    fps_state_e    state_q, state_d;
    logic [3:0]    it_q, it_d;
    logic [9:0]    bin_q, bin_d;
    logic [11:0]   acc_q, acc_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [11:0]   adj;
    logic [21:0]   shifted;
    logic          dp_n;

    assign win_end = enable_i && (gate_q == GATE_LAST);

    always_comb begin
        // an eof on the closing cycle still counts in that window
        frm_inc = (eof_i && frm_q < FMAX) ? frm_q + 10'd1 : frm_q;
        gate_d  = gate_q + 1'b1;
        frm_d   = frm_inc;
        fps_d   = fps_q;
        if (!enable_i) begin
            gate_d = '0;
            frm_d  = '0;
        end else if (win_end) begin
            gate_d = '0;
            frm_d  = '0;
            fps_d  = frm_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        it_d    = it_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        adj     = {dd_adj(acc_q[11:8]), dd_adj(acc_q[7:4]),
                   dd_adj(acc_q[3:0])};
        shifted = {adj[10:0], bin_q, 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    bin_d   = fps_q;
                    acc_d   = '0;
                    it_d    = 4'd0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d = shifted[21:10];
                bin_d = shifted[9:0];
                it_d  = it_q + 4'd1;
                if (it_q == 4'd9) begin
                    // publish on the last shift so bcd_o and valid_o align
                    bcd_d   = shifted[21:10];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gate_q  <= '0;
            frm_q   <= '0;
            fps_q   <= '0;
            start_q <= 1'b0;
            state_q <= ST_IDLE;
            it_q    <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
        end else begin
            gate_q  <= gate_d;
            frm_q   <= frm_d;
            fps_q   <= fps_d;
            start_q <= win_end;
            state_q <= state_d;
            it_q    <= it_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
        end
    end

`ifdef VGA_FPS_DP_EN
    logic dp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dp_q <= 1'b0;
        end else if (win_end) begin
            dp_q <= ~dp_q;
        end
    end

    assign dp_n = ~dp_q;
`else
    assign dp_n = 1'b1;
`endif

    seg7_mux #(
        .DIV(CLK_FREQ_HZ / DIGIT_REFRESH_HZ)
    ) u_mux (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bcd_i (bcd_q),
        .dp_ni (dp_n),
        .seg_o (seg_o),
        .dig_o (dig_o)
    );

    assign fps_o   = fps_q;
    assign bcd_o   = bcd_q;
    assign valid_o = (state_q == ST_DONE);

endmodule
